mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 15, the maximum number of BUSY cycles allowed without dmem_ready before the access is aborted.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-004 SHALL have inputs valid_m 1, regwrite_m 1, result_src_m 2, memwrite_m 1, mem_size_m 3 (funct3), alu_result_m 32, writedata_m 32, rd_m 5 and pc_plus_4_m 32, all carrying the EX/MEM pipeline register contents.
REQ-005 SHALL have outputs dmem_req 1, dmem_we 1, dmem_addr 32 (word-aligned, {alu_result_m[31:2],2'b00}), dmem_be 4 and dmem_wdata 32.
REQ-006 SHALL have inputs dmem_ready 1 and dmem_rdata 32.
REQ-007 SHALL have outputs stall_m 1, misaligned_m 1 and bus_error_m 1.
REQ-008 SHALL have MEM/WB register outputs mem_wb_valid 1, mem_wb_regwrite 1, mem_wb_result_src 2, mem_wb_alu_result 32, mem_wb_read_data 32, mem_wb_pc_plus_4 32 and mem_wb_rd 5.

Function
REQ-009 SHALL classify the instruction as a load when result_src_m==2'b01 and as a store when memwrite_m==1; any other instruction is a non-access.
REQ-010 SHALL treat a halfword access with addr[0]!=0, a word access with addr[1:0]!=0, or mem_size 011/110/111 as misaligned; for such an access SHALL issue no request, pulse misaligned_m for one cycle, and write mem_wb_valid=0 and mem_wb_regwrite=0.
REQ-011 SHALL implement FSM states IDLE and BUSY.
REQ-012 In IDLE with valid_m high and an aligned access, SHALL assert dmem_req combinationally in the same cycle.
REQ-013 On dmem_ready high in that same IDLE cycle (zero-wait access), SHALL complete the access with stall_m=0.
REQ-014 On dmem_ready low in IDLE, SHALL go to BUSY and assert stall_m.
REQ-015 In BUSY, SHALL hold dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata stable and keep stall_m=1 until dmem_ready is high; on ready, SHALL complete the access, return to IDLE and deassert stall_m combinationally.
REQ-016 SHALL count BUSY cycles; when the count reaches WAIT_LIMIT with no ready, SHALL abort, pulse bus_error_m for one cycle, return to IDLE, and write mem_wb_valid=0 and mem_wb_regwrite=0.
REQ-017 SHALL clear the counter on entry to BUSY; dmem_ready arriving in the limit cycle counts as a completion, not a timeout.
REQ-018 Store byte enables: SB, dmem_be=4'b0001<<addr[1:0] and wdata=byte replicated x4; SH, dmem_be=4'b0011<<{addr[1],1'b0} and wdata=half replicated x2; SW, dmem_be=4'b1111.
REQ-019 SHALL drive dmem_be=0 for loads.
REQ-020 SHALL drive dmem_we=memwrite_m.
REQ-021 Load extraction: SHALL select the byte or half from dmem_rdata by addr[1:0]; LB/LH (000/001) sign-extend, LBU/LHU (100/101) zero-extend, and LW (010) passes the word unchanged.
REQ-022 SHALL write the extracted value to mem_wb_read_data on completion.
REQ-023 SHALL pass a non-access instruction to the MEM/WB register in one cycle with no request.
REQ-024 SHALL give every instruction exactly one cycle of latency from completion to MEM/WB.
REQ-025 While stall_m=1, the MEM/WB register SHALL load a bubble (valid=0, regwrite=0, all other fields 0).
REQ-026 SHALL load mem_wb_valid=0 when valid_m=0.
REQ-027 SHALL pass mem_wb_alu_result, mem_wb_pc_plus_4, mem_wb_rd and mem_wb_result_src through unchanged from the completing instruction.
REQ-028 SHALL accept that the upstream stages hold all *_m inputs stable while stall_m=1; dmem_* outputs are derived from these inputs.

Reset
REQ-029 On reset high, SHALL immediately force the FSM to IDLE, the wait counter to 0 and all MEM/WB outputs to 0.
REQ-030 On reset high, SHALL immediately force dmem_req, stall_m, misaligned_m and bus_error_m to 0.
REQ-031 Reset asserted during BUSY SHALL abandon the access with no writeback and no error pulse.

Verification
REQ-032 LW, addr 0x100, ready in the same cycle, rdata 0xDEADBEEF -> stall_m never high; next cycle mem_wb_read_data=0xDEADBEEF, mem_wb_valid=1.
REQ-033 LB, addr 0x103, rdata 0x80FF_0000, ready after 3 cycles -> stall_m high for exactly 3 cycles with 3 bubbles; mem_wb_read_data=0xFFFFFF80.
REQ-034 SH, addr 0x202, writedata 0x0000_1234 -> dmem_be=4'b1100, dmem_wdata=0x1234_1234, dmem_we=1, mem_wb_regwrite=0.
REQ-035 LW, addr 0x101 -> no dmem_req, misaligned_m pulses one cycle, mem_wb_valid=0.
REQ-036 LHU, addr 0x10, ready never asserted, WAIT_LIMIT=15 -> bus_error_m pulses after 15 BUSY cycles, FSM returns to IDLE, no writeback.
REQ-037 Reset asserted in the 2nd BUSY cycle -> dmem_req and stall_m fall immediately; after release, the next ADD passes through with mem_wb_valid=1.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory handshake, shapes stores, extracts loads,
// aborts hung accesses after WAIT_LIMIT wait cycles and holds the MEM/WB register.
module mem_stage #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_m,
    input  logic        regwrite_m,
    input  logic [1:0]  result_src_m,
    input  logic        memwrite_m,
    input  logic [2:0]  mem_size_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] writedata_m,
    input  logic [4:0]  rd_m,
    input  logic [31:0] pc_plus_4_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_m,
    output logic        misaligned_m,
    output logic        bus_error_m,
    output logic        mem_wb_valid,
    output logic        mem_wb_regwrite,
    output logic [1:0]  mem_wb_result_src,
    output logic [31:0] mem_wb_alu_result,
    output logic [31:0] mem_wb_read_data,
    output logic [31:0] mem_wb_pc_plus_4,
    output logic [4:0]  mem_wb_rd
);
    localparam int CNT_W = $clog2(WAIT_LIMIT + 2);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic [1:0]  wb_result_src_q, wb_result_src_d;
    logic [31:0] wb_alu_result_q, wb_alu_result_d;
    logic [31:0] wb_read_data_q, wb_read_data_d;
    logic [31:0] wb_pc_plus_4_q, wb_pc_plus_4_d;
    logic [4:0]  wb_rd_q, wb_rd_d;

    logic        is_load, is_access, misaligned;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        req, stall, mis, berr, kill;

    assign is_load   = (result_src_m == 2'b01);
    assign is_access = is_load | memwrite_m;
    assign off       = alu_result_m[1:0];
    assign misaligned = (mem_size_m == 3'b011) || (mem_size_m == 3'b110) || (mem_size_m == 3'b111)
                     || (mem_size_m[1:0] == 2'b01 && off[0])
                     || (mem_size_m[1:0] == 2'b10 && off != 2'b00);

    assign dmem_addr = {alu_result_m[31:2], 2'b00};
    assign dmem_we   = memwrite_m;

    // Store lane shaping: narrow data is replicated so any lane picked by dmem_be sees it.
    always_comb begin
        dmem_be    = 4'b0000;
        dmem_wdata = writedata_m;
        case (mem_size_m[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << off;
                dmem_wdata = {4{writedata_m[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << {off[1], 1'b0};
                dmem_wdata = {2{writedata_m[15:0]}};
            end
            default: dmem_be = 4'b1111;
        endcase
        if (!memwrite_m) dmem_be = 4'b0000;
    end

    assign ld_byte = dmem_rdata[{off, 3'b000} +: 8];
    assign ld_half = dmem_rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        case (mem_size_m)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    // Handshake FSM; kill marks an instruction that leaves the stage without writeback.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req        = 1'b0;
        stall      = 1'b0;
        mis        = 1'b0;
        berr       = 1'b0;
        kill       = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_m && is_access) begin
                    if (misaligned) begin
                        mis  = 1'b1;
                        kill = 1'b1;
                    end else begin
                        req = 1'b1;
                        if (!dmem_ready) begin
                            stall      = 1'b1;
                            state_d    = BUSY;
                            wait_cnt_d = '0;
                        end
                    end
                end
            end
            BUSY: begin
                req = 1'b1;
                if (dmem_ready) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == LIMIT) begin
                    berr    = 1'b1;
                    kill    = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall      = 1'b1;
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dmem_req     = req & ~reset;
    assign stall_m      = stall & ~reset;
    assign misaligned_m = mis & ~reset;
    assign bus_error_m  = berr & ~reset;

    // MEM/WB next value: a zero bubble unless an instruction completes cleanly this cycle.
    always_comb begin
        wb_valid_d      = 1'b0;
        wb_regwrite_d   = 1'b0;
        wb_result_src_d = 2'b00;
        wb_alu_result_d = 32'h0;
        wb_read_data_d  = 32'h0;
        wb_pc_plus_4_d  = 32'h0;
        wb_rd_d         = 5'd0;
        if (valid_m && !stall && !kill) begin
            wb_valid_d      = 1'b1;
            wb_regwrite_d   = regwrite_m;
            wb_result_src_d = result_src_m;
            wb_alu_result_d = alu_result_m;
            wb_read_data_d  = is_load ? ld_data : 32'h0;
            wb_pc_plus_4_d  = pc_plus_4_m;
            wb_rd_d         = rd_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            wait_cnt_q      <= '0;
            wb_valid_q      <= 1'b0;
            wb_regwrite_q   <= 1'b0;
            wb_result_src_q <= 2'b00;
            wb_alu_result_q <= 32'h0;
            wb_read_data_q  <= 32'h0;
            wb_pc_plus_4_q  <= 32'h0;
            wb_rd_q         <= 5'd0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            wb_valid_q      <= wb_valid_d;
            wb_regwrite_q   <= wb_regwrite_d;
            wb_result_src_q <= wb_result_src_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_pc_plus_4_q  <= wb_pc_plus_4_d;
            wb_rd_q         <= wb_rd_d;
        end
    end

    assign mem_wb_valid      = wb_valid_q;
    assign mem_wb_regwrite   = wb_regwrite_q;
    assign mem_wb_result_src = wb_result_src_q;
    assign mem_wb_alu_result = wb_alu_result_q;
    assign mem_wb_read_data  = wb_read_data_q;
    assign mem_wb_pc_plus_4  = wb_pc_plus_4_q;
    assign mem_wb_rd         = wb_rd_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of zero-wait accesses plus wait, timeout and reset sequences,
// with MEM/WB results checked through an expected-value queue.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_m = 1'b0, regwrite_m = 1'b0, memwrite_m = 1'b0;
    logic [1:0]  result_src_m = 2'b00;
    logic [2:0]  mem_size_m = 3'b000;
    logic [31:0] alu_result_m = 32'h0, writedata_m = 32'h0, pc_plus_4_m = 32'h0;
    logic [4:0]  rd_m = 5'd0;
    logic        dmem_req, dmem_we, dmem_ready = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 32'h0;
    logic [3:0]  dmem_be;
    logic        stall_m, misaligned_m, bus_error_m;
    logic        mem_wb_valid, mem_wb_regwrite;
    logic [1:0]  mem_wb_result_src;
    logic [31:0] mem_wb_alu_result, mem_wb_read_data, mem_wb_pc_plus_4;
    logic [4:0]  mem_wb_rd;

    mem_stage #(.WAIT_LIMIT(15)) dut (
        .clk(clk), .reset(reset), .valid_m(valid_m), .regwrite_m(regwrite_m),
        .result_src_m(result_src_m), .memwrite_m(memwrite_m), .mem_size_m(mem_size_m),
        .alu_result_m(alu_result_m), .writedata_m(writedata_m), .rd_m(rd_m),
        .pc_plus_4_m(pc_plus_4_m), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall_m(stall_m),
        .misaligned_m(misaligned_m), .bus_error_m(bus_error_m),
        .mem_wb_valid(mem_wb_valid), .mem_wb_regwrite(mem_wb_regwrite),
        .mem_wb_result_src(mem_wb_result_src), .mem_wb_alu_result(mem_wb_alu_result),
        .mem_wb_read_data(mem_wb_read_data), .mem_wb_pc_plus_4(mem_wb_pc_plus_4),
        .mem_wb_rd(mem_wb_rd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [1:0]  rsrc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [4:0]  rd;
    } wb_t;
    typedef struct { wb_t wb; wb_t mask; } exp_t;
    typedef struct {
        string       nm;
        logic [1:0]  rsrc;
        logic        mw, rw;
        logic [2:0]  sz;
        logic [31:0] addr, wd, rdata;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] dwd, rd;
    } vec_t;

    int   checks = 0, errors = 0;
    exp_t sb[$];
    vec_t vq[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t e_bubble();
        exp_t e;
        e.wb = '0; e.mask = '1;
        return e;
    endfunction

    function automatic exp_t e_kill();
        exp_t e;
        e.wb = '0; e.mask = '0; e.mask.valid = 1'b1; e.mask.regwrite = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_pass(input logic rw, input logic [1:0] rsrc, input logic [31:0] alu,
                                    input logic [31:0] rdata, input logic [31:0] pc4,
                                    input logic [4:0] rd, input logic ld);
        exp_t e;
        e.wb = '{valid: 1'b1, regwrite: rw, rsrc: rsrc, alu: alu, rdata: rdata, pc4: pc4, rd: rd};
        e.mask = '1;
        if (!ld) e.mask.rdata = '0;
        return e;
    endfunction

    task automatic drive(input logic [1:0] rsrc, input logic mw, input logic rw, input logic [2:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] pc4);
        valid_m = 1'b1; result_src_m = rsrc; memwrite_m = mw; regwrite_m = rw; mem_size_m = sz;
        alu_result_m = addr; writedata_m = wd; rd_m = rd; pc_plus_4_m = pc4;
    endtask

    task automatic add(input string nm, input logic [1:0] rsrc, input logic mw, input logic rw,
                       input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdata, input logic mis, input logic [3:0] be,
                       input logic [31:0] dwd, input logic [31:0] rd);
        vec_t v;
        v.nm = nm; v.rsrc = rsrc; v.mw = mw; v.rw = rw; v.sz = sz; v.addr = addr; v.wd = wd;
        v.rdata = rdata; v.mis = mis; v.be = be; v.dwd = dwd; v.rd = rd;
        vq.push_back(v);
    endtask

    // Advance one clock and compare the MEM/WB register against the oldest expectation.
    task automatic tick(input string nm);
        wb_t  act;
        exp_t e;
        @(posedge clk);
        #1;
        act = '{valid: mem_wb_valid, regwrite: mem_wb_regwrite, rsrc: mem_wb_result_src,
                alu: mem_wb_alu_result, rdata: mem_wb_read_data, pc4: mem_wb_pc_plus_4,
                rd: mem_wb_rd};
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_sb_empty actual=empty expected=entry", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_wb"}, act & e.mask, e.wb & e.mask);
        end
    endtask

    initial begin
        vec_t v;
        logic acc;
        logic [4:0]  vrd;
        logic [31:0] vpc;

        add("lw",     2'b01, 0, 1, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 4'b0000, 32'h0,        32'hDEADBEEF);
        add("lb",     2'b01, 0, 1, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0, 4'b0000, 32'h0,        32'hFFFFFF80);
        add("lbu",    2'b01, 0, 1, 3'b100, 32'h101, 32'h0,        32'h12348056, 0, 4'b0000, 32'h0,        32'h00000080);
        add("lh",     2'b01, 0, 1, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 0, 4'b0000, 32'h0,        32'hFFFF8001);
        add("lhu",    2'b01, 0, 1, 3'b101, 32'h100, 32'h0,        32'h8001F00D, 0, 4'b0000, 32'h0,        32'h0000F00D);
        add("sh",     2'b00, 1, 0, 3'b001, 32'h202, 32'h00001234, 32'h0,        0, 4'b1100, 32'h12341234, 32'h0);
        add("sb",     2'b00, 1, 0, 3'b000, 32'h201, 32'hAABBCCDD, 32'h0,        0, 4'b0010, 32'hDDDDDDDD, 32'h0);
        add("sb3",    2'b00, 1, 0, 3'b000, 32'h203, 32'h000000A5, 32'h0,        0, 4'b1000, 32'hA5A5A5A5, 32'h0);
        add("sw",     2'b00, 1, 0, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0,        0, 4'b1111, 32'hCAFEF00D, 32'h0);
        add("lw_mis", 2'b01, 0, 1, 3'b010, 32'h101, 32'h0,        32'h11111111, 1, 4'b0000, 32'h0,        32'h0);
        add("lh_mis", 2'b01, 0, 1, 3'b001, 32'h103, 32'h0,        32'h11111111, 1, 4'b0000, 32'h0,        32'h0);
        add("sw_mis", 2'b00, 1, 0, 3'b010, 32'h302, 32'h5A5A5A5A, 32'h0,        1, 4'b0000, 32'h0,        32'h0);
        add("ld_bad", 2'b01, 0, 1, 3'b011, 32'h100, 32'h0,        32'h11111111, 1, 4'b0000, 32'h0,        32'h0);
        add("add",    2'b00, 0, 1, 3'b000, 32'h55,  32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0);
        add("jal",    2'b10, 0, 1, 3'b000, 32'h1234,32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0);

        // Reset state.
        #1;
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_stall", stall_m, 1'b0);
        chk("rst_wb_valid", mem_wb_valid, 1'b0);
        chk("rst_wb_data", mem_wb_read_data, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Zero-wait table.
        for (int k = 0; k < vq.size(); k++) begin
            v = vq[k];
            vrd = 5'(k + 1);
            vpc = 32'h400 + 32'(4 * k);
            drive(v.rsrc, v.mw, v.rw, v.sz, v.addr, v.wd, vrd, vpc);
            dmem_ready = 1'b1;
            dmem_rdata = v.rdata;
            acc = (v.rsrc == 2'b01) || v.mw;
            if (v.mis) sb.push_back(e_kill());
            else sb.push_back(e_pass(v.rw, v.rsrc, v.addr, v.rd, vpc, vrd, v.rsrc == 2'b01));
            #3;
            chk({v.nm, "_req"}, dmem_req, acc && !v.mis);
            chk({v.nm, "_mis"}, misaligned_m, v.mis);
            chk({v.nm, "_stall"}, stall_m, 1'b0);
            chk({v.nm, "_we"}, dmem_we, v.mw);
            chk({v.nm, "_addr"}, dmem_addr, {v.addr[31:2], 2'b00});
            if (!v.mis) chk({v.nm, "_be"}, dmem_be, v.be);
            if (v.mw && !v.mis) chk({v.nm, "_wdata"}, dmem_wdata, v.dwd);
            tick(v.nm);
        end

        // valid_m low: no request, no writeback.
        drive(2'b01, 0, 1, 3'b010, 32'h100, 32'h0, 5'd3, 32'h10);
        valid_m = 1'b0;
        sb.push_back(e_kill());
        #3;
        chk("inv_req", dmem_req, 1'b0);
        tick("inv");

        // LB with three wait cycles.
        drive(2'b01, 0, 1, 3'b000, 32'h103, 32'h0, 5'd9, 32'h504);
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        for (int c = 0; c < 3; c++) begin
            sb.push_back(e_bubble());
            #3;
            chk("lbw_stall", stall_m, 1'b1);
            chk("lbw_req", dmem_req, 1'b1);
            chk("lbw_hold", {dmem_addr, dmem_be}, {32'h100, 4'b0000});
            tick("lbw");
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'h80FF0000;
        sb.push_back(e_pass(1'b1, 2'b01, 32'h103, 32'hFFFFFF80, 32'h504, 5'd9, 1'b1));
        #3;
        chk("lbw_done_stall", stall_m, 1'b0);
        tick("lbw_done");

        // LHU never ready: 15 full BUSY cycles, then abort.
        drive(2'b01, 0, 1, 3'b101, 32'h10, 32'h0, 5'd4, 32'h600);
        dmem_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            sb.push_back(e_bubble());
            #3;
            if (stall_m !== 1'b1 || bus_error_m !== 1'b0)
                chk("to_wait", {stall_m, bus_error_m}, 2'b10);
            tick("to_wait");
        end
        sb.push_back(e_kill());
        #3;
        chk("to_berr", bus_error_m, 1'b1);
        chk("to_stall", stall_m, 1'b0);
        tick("to_abort");
        drive(2'b00, 0, 1, 3'b000, 32'h55, 32'h0, 5'd7, 32'h888);
        sb.push_back(e_pass(1'b1, 2'b00, 32'h55, 32'h0, 32'h888, 5'd7, 1'b0));
        #3;
        chk("to_berr_off", bus_error_m, 1'b0);
        chk("to_idle_req", dmem_req, 1'b0);
        tick("to_next");

        // Ready arriving in the limit cycle completes the access.
        drive(2'b01, 0, 1, 3'b010, 32'h20, 32'h0, 5'd5, 32'h700);
        dmem_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            sb.push_back(e_bubble());
            #3;
            tick("lim_wait");
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'h13579BDF;
        sb.push_back(e_pass(1'b1, 2'b01, 32'h20, 32'h13579BDF, 32'h700, 5'd5, 1'b1));
        #3;
        chk("lim_berr", bus_error_m, 1'b0);
        chk("lim_stall", stall_m, 1'b0);
        tick("lim_done");

        // Reset in the second BUSY cycle.
        drive(2'b01, 0, 1, 3'b010, 32'h40, 32'h0, 5'd6, 32'h800);
        dmem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            sb.push_back(e_bubble());
            #3;
            tick("rb_wait");
        end
        #3;
        chk("rb_stall_pre", stall_m, 1'b1);
        reset = 1'b1;
        #1;
        chk("rb_req", dmem_req, 1'b0);
        chk("rb_stall", stall_m, 1'b0);
        chk("rb_berr", bus_error_m, 1'b0);
        @(posedge clk);
        #1;
        chk("rb_wb_valid", mem_wb_valid, 1'b0);
        sb.delete();
        reset = 1'b0;
        drive(2'b00, 0, 1, 3'b000, 32'h77, 32'h0, 5'd8, 32'h900);
        sb.push_back(e_pass(1'b1, 2'b00, 32'h77, 32'h0, 32'h900, 5'd8, 1'b0));
        #3;
        chk("rb_add_req", dmem_req, 1'b0);
        chk("rb_add_stall", stall_m, 1'b0);
        tick("rb_add");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
